// File: rtl/rv_pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package rv_pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LD_STALL = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DIV_WAIT = 3'd3,
        ST_FLUSH    = 3'd4
    } pipe_state_t;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int FCNT_W           = 3;

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter: advances on i_inc, sticks at all-ones, clears on reset.
module rv_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory/divider waits, branch flush.
// Optional divider wait handling is enabled by defining RV_MULDIV_EN.
module rv_pipe_ctrl
    import rv_pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_dec_valid,
    input  logic [4:0]       i_dec_rs1,
    input  logic [4:0]       i_dec_rs2,
    input  logic [4:0]       i_alu_rd,
    input  logic             i_alu_load,
    input  logic             i_alu_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    input  logic             i_div_start,
    input  logic             i_div_done,
    output logic             o_stall_fetch,
    output logic             o_stall_dec,
    output logic             o_stall_alu,
    output logic             o_stall_mem,
    output logic             o_flush_fetch,
    output logic             o_flush_dec,
    output logic             o_bubble_alu,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES - 1);

    pipe_state_t       r_state, r_pend;
    pipe_state_t       w_nxt_state, w_nxt_pend, w_resume;
    logic [FCNT_W-1:0] r_fcnt, w_nxt_fcnt;
    logic              w_mem_wait, w_ld_use, w_div_go;

    assign w_mem_wait = i_mem_req & ~i_mem_ack;
    assign w_ld_use   = i_dec_valid & i_alu_load & (i_alu_rd != 5'd0) &
                        ((i_alu_rd == i_dec_rs1) | (i_alu_rd == i_dec_rs2));

`ifdef RV_MULDIV_EN
    // A divide that completes in its launch cycle never needs a wait.
    assign w_div_go = i_div_start & ~i_div_done;
`else
    logic w_unused_div;
    assign w_div_go     = 1'b0;
    assign w_unused_div = i_div_start ^ i_div_done;
`endif

    // Where to go once an interrupting memory wait is acknowledged.
    always_comb begin
        w_resume = ST_RUN;
        if (r_state == ST_FLUSH) begin
            w_resume = ST_FLUSH;
        end
`ifdef RV_MULDIV_EN
        else if (r_state == ST_DIV_WAIT && !i_div_done) begin
            w_resume = ST_DIV_WAIT;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_pend  <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_pend  <= w_nxt_pend;
            r_fcnt  <= w_nxt_fcnt;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_pend    = r_pend;
        w_nxt_fcnt    = r_fcnt;
        o_stall_fetch = 1'b0;
        o_stall_dec   = 1'b0;
        o_stall_alu   = 1'b0;
        o_stall_mem   = 1'b0;
        o_flush_fetch = 1'b0;
        o_flush_dec   = 1'b0;
        o_bubble_alu  = 1'b0;

        if (r_state == ST_MEM_WAIT) begin
            {o_stall_fetch, o_stall_dec, o_stall_alu, o_stall_mem} = 4'b1111;
            if (i_mem_ack) begin
                w_nxt_state = r_pend;
            end
        end else if (w_mem_wait) begin
            {o_stall_fetch, o_stall_dec, o_stall_alu, o_stall_mem} = 4'b1111;
            w_nxt_state = ST_MEM_WAIT;
            w_nxt_pend  = w_resume;
        end else begin
            case (r_state)
`ifdef RV_MULDIV_EN
                ST_DIV_WAIT: begin
                    {o_stall_fetch, o_stall_dec, o_stall_alu} = 3'b111;
                    if (i_div_done) begin
                        w_nxt_state = ST_RUN;
                    end
                end
`endif
                ST_FLUSH: begin
                    o_flush_fetch = 1'b1;
                    o_flush_dec   = 1'b1;
                    w_nxt_fcnt    = r_fcnt - FCNT_W'(1);
                    if (r_fcnt <= FCNT_W'(1)) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_fcnt  = '0;
                    end
                end
                default: begin
                    w_nxt_state = ST_RUN;
                    if (w_div_go) begin
                        w_nxt_state = ST_DIV_WAIT;
                    end else if (i_alu_branch_taken) begin
                        o_flush_fetch = 1'b1;
                        o_flush_dec   = 1'b1;
                        w_nxt_fcnt    = FLUSH_INIT;
                        if (FLUSH_INIT != '0) begin
                            w_nxt_state = ST_FLUSH;
                        end
                    end else if (r_state == ST_RUN && w_ld_use) begin
                        // LD_STALL blocks a second back-to-back bubble for the same pair.
                        o_stall_fetch = 1'b1;
                        o_stall_dec   = 1'b1;
                        o_bubble_alu  = 1'b1;
                        w_nxt_state   = ST_LD_STALL;
                    end
                end
            endcase
        end
    end

    rv_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_stall_fetch),
        .o_count (o_stall_cnt)
    );

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Bench for rv_pipe_ctrl: directed literal checks plus randomized traffic vs. a behavioural model.
module tb_rv_pipe_ctrl;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef RV_MULDIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_dec_valid = 1'b0;
    logic [4:0]    i_dec_rs1 = '0, i_dec_rs2 = '0, i_alu_rd = '0;
    logic          i_alu_load = 1'b0, i_alu_branch_taken = 1'b0;
    logic          i_mem_req = 1'b0, i_mem_ack = 1'b0;
    logic          i_div_start = 1'b0, i_div_done = 1'b0;
    logic          o_stall_fetch, o_stall_dec, o_stall_alu, o_stall_mem;
    logic          o_flush_fetch, o_flush_dec, o_bubble_alu;
    logic [CW-1:0] o_stall_cnt;
    logic [6:0]    dut_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_dec_valid(i_dec_valid),
        .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_alu_rd(i_alu_rd),
        .i_alu_load(i_alu_load), .i_alu_branch_taken(i_alu_branch_taken),
        .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
        .i_div_start(i_div_start), .i_div_done(i_div_done),
        .o_stall_fetch(o_stall_fetch), .o_stall_dec(o_stall_dec),
        .o_stall_alu(o_stall_alu), .o_stall_mem(o_stall_mem),
        .o_flush_fetch(o_flush_fetch), .o_flush_dec(o_flush_dec),
        .o_bubble_alu(o_bubble_alu), .o_stall_cnt(o_stall_cnt)
    );

    assign dut_out = {o_stall_fetch, o_stall_dec, o_stall_alu, o_stall_mem,
                      o_flush_fetch, o_flush_dec, o_bubble_alu};

    // Behavioural model: pending waits and remaining flush cycles as plain flags/integers.
    bit m_live = 1'b0;
    bit m_mem = 1'b0, m_div = 1'b0, m_after_ld = 1'b0;
    int m_flush_left = 0, m_cnt = 0;

    always @(negedge clk) begin
        logic [6:0] e_out;
        bit mw, lu;
        mw = i_mem_req && !i_mem_ack;
        lu = i_dec_valid && i_alu_load && (i_alu_rd != 0) &&
             (i_alu_rd == i_dec_rs1 || i_alu_rd == i_dec_rs2);
        e_out = 7'b0;
        if (m_live) begin
            if (m_mem) begin
                e_out = 7'b1111000;
                if (i_mem_ack) m_mem = 1'b0;
                m_after_ld = 1'b0;
            end else if (mw) begin
                e_out = 7'b1111000;
                m_mem = 1'b1;
                if (m_div && i_div_done) m_div = 1'b0;
                m_after_ld = 1'b0;
            end else if (m_div) begin
                e_out = 7'b1110000;
                if (i_div_done) m_div = 1'b0;
            end else if (m_flush_left > 0) begin
                e_out = 7'b0000110;
                m_flush_left--;
                m_after_ld = 1'b0;
            end else if (DIV_EN && i_div_start && !i_div_done) begin
                m_div = 1'b1;
                m_after_ld = 1'b0;
            end else if (i_alu_branch_taken) begin
                e_out = 7'b0000110;
                m_flush_left = FC - 1;
                m_after_ld = 1'b0;
            end else if (!m_after_ld && lu) begin
                e_out = 7'b1100001;
                m_after_ld = 1'b1;
            end else begin
                m_after_ld = 1'b0;
            end
            checks++;
            if (dut_out !== e_out) begin
                failures++;
                $display("FAIL model_out t=%0t got=%b want=%b", $time, dut_out, e_out);
            end
            checks++;
            if (int'(o_stall_cnt) != m_cnt) begin
                failures++;
                $display("FAIL model_cnt t=%0t got=%0d want=%0d", $time, o_stall_cnt, m_cnt);
            end
            if (e_out[6] && m_cnt < CMAX) m_cnt++;
        end
        if (i_reset) begin
            m_live = 1'b1; m_mem = 1'b0; m_div = 1'b0; m_after_ld = 1'b0;
            m_flush_left = 0; m_cnt = 0;
        end
    end

    task automatic drv(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic mq, input logic ma);
        i_reset = 1'b0; i_dec_valid = dv; i_dec_rs1 = r1; i_dec_rs2 = r2;
        i_alu_rd = rd; i_alu_load = ld; i_alu_branch_taken = br;
        i_mem_req = mq; i_mem_ack = ma; i_div_start = 1'b0; i_div_done = 1'b0;
    endtask

    task automatic cyc(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic mq, input logic ma);
        @(posedge clk); #1;
        drv(dv, r1, r2, rd, ld, br, mq, ma);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    // Literal expectations; ec < 0 skips the counter comparison.
    task automatic pin(input string nm, input logic [6:0] eo, input int ec);
        #3;
        checks++;
        if (dut_out !== eo) begin
            failures++;
            $display("FAIL %s out got=%b want=%b", nm, dut_out, eo);
        end
        if (ec >= 0) begin
            checks++;
            if (int'(o_stall_cnt) != ec) begin
                failures++;
                $display("FAIL %s cnt got=%0d want=%0d", nm, o_stall_cnt, ec);
            end
        end
    endtask

    initial begin
        do_reset();                          pin("reset_idle", 7'b0000000, 0);
        cyc(1, 1, 5, 5, 1, 0, 0, 0);         pin("lu_hit",     7'b1100001, 0);
        idle();                              pin("lu_after",   7'b0000000, 1);
        cyc(1, 0, 0, 0, 1, 0, 0, 0);         pin("lu_rd0",     7'b0000000, 1);

        do_reset();                          pin("rst2",       7'b0000000, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);         pin("mem_c0",     7'b1111000, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);         pin("mem_c1",     7'b1111000, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);         pin("mem_c2",     7'b1111000, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);         pin("mem_ack",    7'b1111000, 3);
        idle();                              pin("mem_done",   7'b0000000, 4);

        cyc(0, 0, 0, 0, 0, 1, 0, 0);         pin("br_c0",      7'b0000110, 4);
        idle();                              pin("br_c1",      7'b0000110, 4);
        idle();                              pin("br_end",     7'b0000000, 4);
        cyc(1, 7, 0, 7, 1, 1, 0, 0);         pin("br_lu",      7'b0000110, 4);
        idle();                              pin("br_lu_c1",   7'b0000110, 4);
        idle();                              pin("br_lu_end",  7'b0000000, 4);

        cyc(0, 0, 0, 0, 0, 1, 0, 0);         pin("brm_c0",     7'b0000110, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);         pin("brm_mem",    7'b1111000, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);         pin("brm_ack",    7'b1111000, 5);
        idle();                              pin("brm_resume", 7'b0000110, 6);
        idle();                              pin("brm_end",    7'b0000000, 6);

        cyc(0, 0, 0, 0, 0, 1, 1, 0);         pin("brs_c0",     7'b1111000, 6);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);         pin("brs_ack",    7'b1111000, 7);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);         pin("brs_act",    7'b0000110, 8);
        idle();                              pin("brs_c1",     7'b0000110, 8);
        idle();                              pin("brs_end",    7'b0000000, 8);

        cyc(0, 0, 0, 0, 0, 1, 0, 0);         pin("brlu_c0",    7'b0000110, 8);
        cyc(1, 3, 0, 3, 1, 0, 0, 0);         pin("brlu_ign",   7'b0000110, 8);
        cyc(1, 3, 0, 3, 1, 0, 0, 0);         pin("brlu_run",   7'b1100001, 8);
        idle();                              pin("brlu_end",   7'b0000000, 9);

        cyc(0, 0, 0, 0, 0, 0, 1, 0);         pin("rm_c0",      7'b1111000, 9);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);         pin("rm_c1",      7'b1111000, 10);
        do_reset();                          pin("rm_after",   7'b0000000, 0);
        idle();                              pin("rm_after2",  7'b0000000, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);         pin("rf_c0",      7'b0000110, 0);
        do_reset();                          pin("rf_after",   7'b0000000, 0);

`ifdef RV_MULDIV_EN
        idle(); i_div_start = 1'b1;          pin("div_start",  7'b0000000, 0);
        for (int k = 0; k < 4; k++) begin
            idle();                          pin("div_wait",   7'b1110000, -1);
        end
        idle(); i_div_done = 1'b1;           pin("div_done",   7'b1110000, 4);
        idle();                              pin("div_end",    7'b0000000, 5);
        idle(); i_div_start = 1'b1;          pin("div2_start", 7'b0000000, 5);
        idle();                              pin("div2_c1",    7'b1110000, 5);
        do_reset();                          pin("div_rst",    7'b0000000, 0);
`else
        idle(); i_div_start = 1'b1;          pin("div_ignored", 7'b0000000, 0);
        idle(); i_div_done = 1'b1;           pin("div_ignored2", 7'b0000000, 0);
`endif

        do_reset();
        for (int k = 0; k < (1 << CW) + 2; k++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);         pin("sat_ack",    7'b1111000, CMAX);
        idle();                              pin("sat_hold",   7'b0000000, CMAX);

        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 2) == 0));
            i_div_start = 1'($urandom_range(0, 7) == 0);
            i_div_done  = 1'($urandom_range(0, 3) == 0);
            i_reset     = 1'($urandom_range(0, 299) == 0);
        end
        idle();
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
